// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM data-port OBI arbiter.
// Latency: n/a (types, constants and a pure range-check helper only).
// Backpressure: n/a.
package sram_pkg;

    localparam logic [31:0] SRAM_BASE_ADDR_DFLT = 32'h8000_0000;
    localparam logic [31:0] SRAM_END_ADDR_DFLT  = 32'h8000_C000;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    // Outstanding-access tracker: one slot is enough because the SRAM
    // always answers exactly one cycle after its grant.
    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } trk_t;

    // Unsigned 32-bit window check, lower bound inclusive, upper exclusive.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter producing a one-hot grant.
// Latency: combinational grant; priority state updates on the clock edge.
// Backpressure: none; the losing requester is expected to hold its request.
// Ports: clk_i/rst_ni clock and async active-low reset, req_i[1:0] requests,
//        gnt_o[1:0] one-hot winner (all-zero when nobody requests).
module sram_rr_arb2 #(
    parameter logic M1_INIT_PRIO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // prio_q names the master that wins a tie.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Contention hands priority to this cycle's loser.
    assign prio_d = (req_i == 2'b11) ? ~prio_q : prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= M1_INIT_PRIO;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sram_d_obi_arb.sv
// Two-master OBI arbiter feeding the SRAM wrapper data port, with range check
// and sticky first-illegal-address capture. Latency: grant same cycle,
// response one cycle later. Backpressure: legal winner is granted by s_gnt_i,
// illegal winner is granted locally; loser waits with its request held.
// Ports: m0_* core data master, m1_* host/debug master, s_* SRAM wrapper side,
//        err_valid_o/err_addr_o/err_clear_i illegal-address capture.
// Optional: define SRAM_ARB_PERF_EN to add perf_contention_o / perf_illegal_o
//           saturating counters (cleared by err_clear_i).
module sram_d_obi_arb
    import sram_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR = SRAM_BASE_ADDR_DFLT,
    parameter logic [31:0] SRAM_END_ADDR  = SRAM_END_ADDR_DFLT,
    parameter logic        M1_INIT_PRIO   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,

    input  logic        err_clear_i,
`ifdef SRAM_ARB_PERF_EN
    output logic [31:0] perf_contention_o,
    output logic [31:0] perf_illegal_o,
`endif
    output logic        err_valid_o,
    output logic [31:0] err_addr_o
);

    obi_req_t   m_req [2];
    obi_req_t   win_req;
    logic [1:0] arb_gnt;
    logic       win_vld;
    logic       win_id;
    logic       win_legal;
    logic       win_gnt;
    trk_t       trk_d;
    trk_t       trk_q;
    obi_rsp_t   rsp;
    logic       err_valid_q;
    logic [31:0] err_addr_q;

    assign m_req[0] = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign m_req[1] = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

    sram_rr_arb2 #(
        .M1_INIT_PRIO (M1_INIT_PRIO)
    ) u_rr_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  ({m1_req_i, m0_req_i}),
        .gnt_o  (arb_gnt)
    );

    assign win_vld   = |arb_gnt;
    assign win_id    = arb_gnt[1];
    assign win_req   = win_id ? m_req[1] : m_req[0];
    assign win_legal = addr_in_range(win_req.addr, SRAM_BASE_ADDR, SRAM_END_ADDR);

    // Illegal accesses never reach the SRAM; they are completed locally so
    // the master is not stalled forever and gets an error response instead.
    assign s_req_o   = win_vld & win_legal;
    assign s_addr_o  = s_req_o ? win_req.addr  : '0;
    assign s_we_o    = s_req_o ? win_req.we    : 1'b0;
    assign s_be_o    = s_req_o ? win_req.be    : '0;
    assign s_wdata_o = s_req_o ? win_req.wdata : '0;

    assign win_gnt  = win_vld & (win_legal ? s_gnt_i : 1'b1);
    assign m0_gnt_o = win_gnt & ~win_id;
    assign m1_gnt_o = win_gnt &  win_id;

    assign trk_d = '{valid: win_gnt, id: win_id, err: win_gnt & ~win_legal};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_q <= '0;
        end else begin
            trk_q <= trk_d;
        end
    end

    // Response of the access granted last cycle, routed by the tracker.
    // SRAM responses that arrive with no legal access outstanding are dropped.
    always_comb begin
        rsp        = '0;
        rsp.rvalid = trk_q.valid & (trk_q.err | s_rvalid_i);
        rsp.err    = trk_q.valid & trk_q.err;
        if (trk_q.valid && !trk_q.err && s_rvalid_i) begin
            rsp.rdata = s_rdata_i;
        end
    end

    assign m0_rvalid_o = (trk_q.id == 1'b0) ? rsp.rvalid : 1'b0;
    assign m0_rdata_o  = (trk_q.id == 1'b0) ? rsp.rdata  : '0;
    assign m0_err_o    = (trk_q.id == 1'b0) ? rsp.err    : 1'b0;
    assign m1_rvalid_o = (trk_q.id == 1'b1) ? rsp.rvalid : 1'b0;
    assign m1_rdata_o  = (trk_q.id == 1'b1) ? rsp.rdata  : '0;
    assign m1_err_o    = (trk_q.id == 1'b1) ? rsp.err    : 1'b0;

    // First illegal address is kept until software clears it; a clear in the
    // same cycle as a new capture wins and that capture is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_clear_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (trk_d.err && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= win_req.addr;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_cont_q;
    logic [31:0] perf_ill_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cont_q <= '0;
            perf_ill_q  <= '0;
        end else if (err_clear_i) begin
            perf_cont_q <= '0;
            perf_ill_q  <= '0;
        end else begin
            if (m0_req_i && m1_req_i && (perf_cont_q != 32'hFFFF_FFFF)) begin
                perf_cont_q <= perf_cont_q + 32'd1;
            end
            if (trk_d.err && (perf_ill_q != 32'hFFFF_FFFF)) begin
                perf_ill_q <= perf_ill_q + 32'd1;
            end
        end
    end

    assign perf_contention_o = perf_cont_q;
    assign perf_illegal_o    = perf_ill_q;
`endif

    // The SRAM may only answer the cycle after a legal grant.
    rsp_only_when_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        s_rvalid_i |-> (trk_q.valid && !trk_q.err));

endmodule

// File: tb/tb_sram_d_obi_arb.sv
// Self-checking bench for sram_d_obi_arb: directed scenarios then random
// traffic, compared each cycle against a transaction-level reference model.
module tb_sram_d_obi_arb;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] LIM  = 32'h8000_C000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        req, we, gnt, rvalid, rerr;
    logic [1:0][31:0]  addr, wdata, rdata;
    logic [1:0][3:0]   be;
    logic              s_req, s_gnt, s_we, s_rvalid;
    logic [31:0]       s_addr, s_wdata, s_rdata;
    logic [3:0]        s_be;
    logic              err_valid, err_clear;
    logic [31:0]       err_addr;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0]       perf_cont, perf_ill;
`endif

    sram_d_obi_arb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[0]), .m0_gnt_o(gnt[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_be_i(be[0]), .m0_wdata_i(wdata[0]), .m0_rvalid_o(rvalid[0]),
        .m0_rdata_o(rdata[0]), .m0_err_o(rerr[0]),
        .m1_req_i(req[1]), .m1_gnt_o(gnt[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_be_i(be[1]), .m1_wdata_i(wdata[1]), .m1_rvalid_o(rvalid[1]),
        .m1_rdata_o(rdata[1]), .m1_err_o(rerr[1]),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_clear_i(err_clear),
`ifdef SRAM_ARB_PERF_EN
        .perf_contention_o(perf_cont), .perf_illegal_o(perf_ill),
`endif
        .err_valid_o(err_valid), .err_addr_o(err_addr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: who wins a tie, the one outstanding access,
    // the captured error and the performance counts.
    bit          prio;
    bit          pend_vld, pend_id, pend_err;
    logic [31:0] pend_data, rd_pick;
    bit          m_err_v;
    logic [31:0] m_err_a, m_cont, m_ill;
    bit          e_win_vld, e_win, e_legal, e_sreq;
    logic [1:0]  e_gnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(9))
            0: return BASE - 32'd1;
            1: return BASE;
            2: return LIM - 32'd1;
            3: return LIM;
            4: return 32'h0;
            5: return 32'hFFFF_FFFF;
            default: return BASE + ($urandom_range(32'h2FFF) << 2);
        endcase
    endfunction

    // Called just after a rising edge: drives the SRAM side, waits to the
    // falling edge and compares every output against the model.
    task automatic eval_check();
        logic [1:0]       er, ee;
        logic [1:0][31:0] ed;
        s_rvalid = pend_vld && !pend_err;
        s_rdata  = s_rvalid ? pend_data : $urandom();
        #4;
        e_win_vld = (req != 2'b00);
        e_win     = (req == 2'b11) ? prio : req[1];
        e_legal   = (addr[e_win] >= BASE) && (addr[e_win] < LIM);
        e_sreq    = e_win_vld && e_legal;
        e_gnt     = 2'b00;
        if (e_win_vld) e_gnt[e_win] = e_legal ? s_gnt : 1'b1;
        er = 2'b00; ee = 2'b00; ed = '0;
        if (pend_vld) begin
            er[pend_id] = 1'b1;
            ee[pend_id] = pend_err;
            ed[pend_id] = pend_err ? 32'h0 : pend_data;
        end
        check_val("gnt", gnt, e_gnt);
        check_val("s_req", s_req, e_sreq);
        check_val("s_addr", s_addr, e_sreq ? addr[e_win] : 32'h0);
        check_val("s_ctl", {s_we, s_be}, e_sreq ? {we[e_win], be[e_win]} : 5'd0);
        check_val("s_wdata", s_wdata, e_sreq ? wdata[e_win] : 32'h0);
        check_val("rvalid", rvalid, er);
        check_val("rerr", rerr, ee);
        check_val("rdata0", rdata[0], ed[0]);
        check_val("rdata1", rdata[1], ed[1]);
        check_val("err_valid", err_valid, m_err_v);
        check_val("err_addr", err_addr, m_err_a);
`ifdef SRAM_ARB_PERF_EN
        check_val("perf_cont", perf_cont, m_cont);
        check_val("perf_ill", perf_ill, m_ill);
`endif
    endtask

    // Advances the model by one clock and moves to just after the next edge.
    task automatic commit();
        bit granted;
        granted = (e_gnt != 2'b00);
        if (err_clear) begin
            m_err_v = 1'b0; m_err_a = 32'h0; m_cont = 32'h0; m_ill = 32'h0;
        end else begin
            if (granted && !e_legal && !m_err_v) begin
                m_err_v = 1'b1; m_err_a = addr[e_win];
            end
            if (req == 2'b11 && m_cont != 32'hFFFF_FFFF) m_cont++;
            if (granted && !e_legal && m_ill != 32'hFFFF_FFFF) m_ill++;
        end
        if (req == 2'b11) prio = ~e_win;
        pend_vld  = granted;
        pend_id   = e_win;
        pend_err  = granted && !e_legal;
        pend_data = rd_pick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00; err_clear = 1'b0; s_gnt = 1'b1;
        rst_n = 1'b0;
        prio = 1'b0; pend_vld = 1'b0; m_err_v = 1'b0; m_err_a = 32'h0;
        m_cont = 32'h0; m_ill = 32'h0; e_gnt = 2'b00;
        eval_check();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
        req[m] = 1'b1; addr[m] = a; we[m] = w; be[m] = 4'hF; wdata[m] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time budget");
        $fatal(1);
    end

    initial begin
        req = 0; addr = '0; we = 0; be = '0; wdata = '0; s_gnt = 0;
        s_rvalid = 0; s_rdata = 0; err_clear = 0; rd_pick = 0;
        do_reset();

        // Single read by m0.
        set_m(0, 32'h8000_0010, 1'b0, 32'h0); rd_pick = 32'hDEAD_BEEF;
        eval_check(); check_val("t1_gnt", gnt, 2'b01); commit();
        req = 0;
        eval_check();
        check_val("t1_rvalid", rvalid, 2'b01);
        check_val("t1_rdata", rdata[0], 32'hDEAD_BEEF);
        check_val("t1_m1_quiet", {rerr[1], rdata[1]}, 33'h0);
        commit();

        // Continuous contention after reset alternates starting with m0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_m(0, BASE + 32'h100 + k * 4, 1'b0, 32'h0);
            set_m(1, BASE + 32'h200 + k * 4, 1'b0, 32'h0);
            rd_pick = 32'h5A00_0000 + k;
            eval_check();
            check_val("t2_alt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            commit();
        end
        req = 0; eval_check(); commit();

        // Illegal write by m1 at the exclusive upper bound.
        set_m(1, LIM, 1'b1, 32'h1234);
        eval_check();
        check_val("t3_sreq", s_req, 1'b0);
        check_val("t3_gnt", gnt, 2'b10);
        commit();
        req = 0;
        eval_check();
        check_val("t3_rsp", {rvalid, rerr, rdata[1]}, {2'b10, 2'b10, 32'h0});
        check_val("t3_cap", {err_valid, err_addr}, {1'b1, LIM});
        commit();

        // Second illegal access does not overwrite; clear then empties.
        set_m(0, 32'h0000_0004, 1'b0, 32'h0);
        eval_check(); commit();
        req = 0;
        eval_check(); check_val("t4_hold", err_addr, LIM); commit();
        err_clear = 1'b1;
        eval_check(); commit();
        err_clear = 1'b0;
        eval_check(); check_val("t4_clr", {err_valid, err_addr}, 33'h0); commit();

        // Reset right after a grant discards the response.
        set_m(0, BASE + 32'h40, 1'b0, 32'h0); rd_pick = 32'hCAFE_0001;
        eval_check(); commit();
        rst_n = 1'b0; req = 0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
        #1;
        check_val("t5_rst_rsp", {rvalid, rdata[0]}, 34'h0);
        do_reset();
        eval_check(); check_val("t5_post", rvalid, 2'b00); commit();

`ifdef SRAM_ARB_PERF_EN
        for (int k = 0; k < 3; k++) begin
            set_m(0, BASE + k * 4, 1'b0, 32'h0);
            set_m(1, BASE + 32'h80 + k * 4, 1'b0, 32'h0);
            eval_check(); commit();
        end
        req = 0;
        for (int k = 0; k < 2; k++) begin
            set_m(1, 32'h1000 + k * 4, 1'b0, 32'h0);
            eval_check(); commit();
        end
        req = 0;
        eval_check(); check_val("t6_perf", {perf_cont, perf_ill}, {32'd3, 32'd2}); commit();
        err_clear = 1'b1; eval_check(); commit(); err_clear = 1'b0;
        eval_check(); check_val("t6_clr", {perf_cont, perf_ill}, 64'h0); commit();
`endif

        // Random traffic; a master not granted keeps its request unchanged.
        req = 0; e_gnt = 2'b00;
        for (int c = 0; c < 500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(req[m] && !e_gnt[m])) begin
                    req[m]   = ($urandom_range(9) < 7);
                    addr[m]  = pick_addr();
                    we[m]    = 1'($urandom());
                    be[m]    = 4'($urandom());
                    wdata[m] = $urandom();
                end
            end
            s_gnt     = ($urandom_range(7) != 0);
            err_clear = ($urandom_range(19) == 0);
            rd_pick   = $urandom();
            eval_check();
            commit();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_d_obi_arb.md
Name: sram_d_obi_arb

Overview:
- Two-master OBI arbiter that sits directly upstream of the SRAM wrapper's data port and produces its "muxed" sram_d request stream.
- Master 0 is the core data port; master 1 is the host/debug bridge.
- Round-robin arbitration, in-range address check, response routing by a tracking register, and first-illegal-address capture.
- The downstream SRAM grants in the same cycle as the request and returns rvalid exactly one cycle later; this block relies on that fixed timing.

Parameters:
- SRAM_BASE_ADDR, 32'h8000_0000, lowest legal byte address (inclusive).
- SRAM_END_ADDR, 32'h8000_C000, end of legal range (exclusive).
- M1_INIT_PRIO, 1'b0, master that has priority after reset (0 or 1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m{0,1}_req_i  in  1  master request
- m{0,1}_gnt_o  out  1  master grant
- m{0,1}_addr_i  in  32  byte address
- m{0,1}_we_i  in  1  write enable
- m{0,1}_be_i  in  4  byte enables
- m{0,1}_wdata_i  in  32  write data
- m{0,1}_rvalid_o  out  1  response valid
- m{0,1}_rdata_o  out  32  read data
- m{0,1}_err_o  out  1  response error (valid with rvalid)
- s_req_o  out  1  request to SRAM wrapper
- s_gnt_i  in  1  SRAM grant
- s_addr_o  out  32  muxed address
- s_we_o  out  1  muxed write enable
- s_be_o  out  4  muxed byte enables
- s_wdata_o  out  32  muxed write data
- s_rvalid_i  in  1  SRAM response valid
- s_rdata_i  in  32  SRAM read data
- err_valid_o  out  1  sticky: illegal address captured
- err_addr_o  out  32  first illegal address since last clear
- err_clear_i  in  1  clears err_valid_o / err_addr_o

Behaviour:
- Legal address: SRAM_BASE_ADDR <= addr < SRAM_END_ADDR, compared unsigned at 32 bits.
- Arbitration (combinational, one winner per cycle):
  - Only one requester: it wins.
  - Both requesting: the master named by prio_q wins.
  - prio_q flips to the loser whenever both request in the same cycle; otherwise unchanged.
  - Reset value of prio_q = M1_INIT_PRIO.
- Legal winner:
  - s_req_o=1; s_addr/we/be/wdata carry the winner's fields.
  - Winner's gnt = s_gnt_i.
- Illegal winner:
  - s_req_o=0; winner's gnt=1 (granted locally).
  - Write data is dropped; no SRAM side-effect.
- s_* data outputs are driven to 0 when s_req_o=0.
- Loser's gnt=0; the loser holds its request (OBI rule).
- Tracking register trk = {valid, id, err}:
  - Loaded every cycle: valid = a grant occurred, id = winner, err = illegal.
  - Reset value 0.
- Response cycle (cycle after grant, trk.valid=1):
  - m[trk.id]_rvalid_o = trk.err ? 1 : s_rvalid_i.
  - rdata = trk.err ? 0 : s_rdata_i.
  - err_o = trk.err.
  - The other master sees rvalid=0, rdata=0, err=0.
- s_rvalid_i while trk.valid=0 or trk.err=1: response is ignored (protocol violation; assertion in sim).
- Back-to-back grants every cycle are supported; throughput is one access per cycle, latency one cycle.
- Error capture:
  - On an illegal grant with err_valid_o=0: err_addr_o <= address, err_valid_o <= 1.
  - Later illegal grants do not overwrite the captured address.
  - err_clear_i has priority over a same-cycle capture; the clear wins and that capture is lost.
- Reset values: all outputs 0, including err_valid_o, err_addr_o and trk.
- Asynchronous reset mid-transaction: the pending response is discarded and no rvalid is issued after reset release.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- With macro:
  - Adds outputs perf_contention_o[31:0] (cycles where both masters requested) and perf_illegal_o[31:0] (illegal grants).
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and clear on err_clear_i.
- Without macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package sram_pkg:
  - obi_req_t {addr, we, be, wdata}
  - obi_rsp_t {rvalid, rdata, err}
  - trk_t {valid, id, err}
  - SRAM_BASE_ADDR / SRAM_END_ADDR defaults
- One natural sub-module: sram_rr_arb2, the 2-input round-robin arbiter holding prio_q and outputting a one-hot grant.
- Mux, range check, tracking and capture logic stay in the top.

Test Plan:
- Only m0 reads 0x8000_0010 and the SRAM returns 0xDEAD_BEEF -> m0 gnt in the same cycle; next cycle m0_rvalid=1, rdata=0xDEAD_BEEF, err=0; m1 stays silent.
- Both masters request continuously for 4 cycles after reset (M1_INIT_PRIO=0) -> grants m0,m1,m0,m1; each response is routed to the matching master one cycle later.
- m1 writes 0x8000_C000 with data 0x1234 -> s_req_o=0, m1_gnt=1; next cycle m1_rvalid=1, err=1, rdata=0; err_valid_o=1, err_addr_o=0x8000_C000.
- Second illegal access to 0x0000_0004, then err_clear_i pulse -> err_addr_o holds 0x8000_C000 until the clear, then 0 / err_valid_o=0.
- Grant in cycle t, rst_ni asserted during t+1 -> no rvalid on either master; all outputs are 0 during reset and on release.
- With SRAM_ARB_PERF_EN, 3 contention cycles and 2 illegal grants -> perf_contention_o=3, perf_illegal_o=2; err_clear_i returns both to 0.
